// File: rtl/pwm_shadow_regs_if.sv
// Register-bus interface between the AXI4-Lite decoder and the PWM shadow register file.
// The decoder side uses the master modport; the register file uses the slave modport.
interface pwm_shadow_regs_if #(
    parameter int unsigned REG_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned STRB_WIDTH = REG_WIDTH / 8;

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [REG_WIDTH-1:0]  write_data;
    logic [STRB_WIDTH-1:0] write_strb;
    logic                  write_err;

    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [REG_WIDTH-1:0]  read_data;
    logic                  read_valid;
    logic                  read_err;

    modport master (
        output write_en, write_addr, write_data, write_strb, read_en, read_addr,
        input  write_err, read_data, read_valid, read_err
    );

    modport slave (
        input  write_en, write_addr, write_data, write_strb, read_en, read_addr,
        output write_err, read_data, read_valid, read_err
    );
endinterface

// File: rtl/pwm_shadow_regs.sv
// Double-buffered PWM register file: software writes staging registers, and the PWM core
// sees active registers that are refreshed from staging only on a requested period boundary.
module pwm_shadow_regs #(
    parameter int unsigned REG_WIDTH    = 16,
    parameter int unsigned NUM_CHANNELS = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    pwm_shadow_regs_if.slave                        bus,
    input  logic                                    i_period_end,
    output logic                                    o_enable,
    output logic                                    o_update_pending,
    output logic [REG_WIDTH-1:0]                    o_prescale,
    output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  o_period,
    output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  o_duty
);
    localparam int unsigned DEPTH         = 3 + 2 * NUM_CHANNELS;
    localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH);
    localparam int unsigned STRB_WIDTH    = REG_WIDTH / 8;
    localparam int unsigned ADDR_CTRL     = 0;
    localparam int unsigned ADDR_STATUS   = 1;
    localparam int unsigned ADDR_PRESCALE = 2;
    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_UPDATE   = 1;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [REG_WIDTH-1:0] f_merge(
        input logic [REG_WIDTH-1:0]  old_val,
        input logic [REG_WIDTH-1:0]  new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [REG_WIDTH-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_period_addr(input int unsigned ch);
        return ADDR_WIDTH'(3 + 2 * ch);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_duty_addr(input int unsigned ch);
        return ADDR_WIDTH'(4 + 2 * ch);
    endfunction

    // Software-visible state
    logic                                   r_enable;
    logic                                   r_pending;
    logic [REG_WIDTH-1:0]                   r_prescale_stg;
    logic [REG_WIDTH-1:0]                   r_period_stg [NUM_CHANNELS];
    logic [REG_WIDTH-1:0]                   r_duty_stg   [NUM_CHANNELS];

    // Active copies driven to the PWM core
    logic [REG_WIDTH-1:0]                   r_prescale_act;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_period_act;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_duty_act;

    // Bus response registers
    logic [REG_WIDTH-1:0]                   r_read_data;
    logic                                   r_read_valid;
    logic                                   r_read_err;
    logic                                   r_write_err;

    logic                                   w_wr_in_range;
    logic                                   w_rd_in_range;
    logic                                   w_wr_ok;
    logic                                   w_ctrl_lane0_wr;
    logic                                   w_update_req;
    logic                                   w_commit;
    logic [REG_WIDTH-1:0]                   w_rd_word;

    assign w_wr_in_range   = 32'(bus.write_addr) < DEPTH;
    assign w_rd_in_range   = 32'(bus.read_addr) < DEPTH;
    assign w_wr_ok         = bus.write_en && w_wr_in_range;
    assign w_ctrl_lane0_wr = w_wr_ok && (bus.write_addr == ADDR_WIDTH'(ADDR_CTRL))
                             && bus.write_strb[0];
    assign w_update_req    = w_ctrl_lane0_wr && bus.write_data[CTRL_UPDATE];

    // Disabled PWM tracks staging continuously; enabled PWM only takes a requested boundary.
    assign w_commit        = !r_enable || (i_period_end && r_pending);

    // Staging registers; STATUS and out-of-range addresses never match here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_stg <= '0;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_period_stg[ch] <= '0;
                r_duty_stg[ch]   <= '0;
            end
        end else if (w_wr_ok) begin
            if (bus.write_addr == ADDR_WIDTH'(ADDR_PRESCALE)) begin
                r_prescale_stg <= f_merge(r_prescale_stg, bus.write_data, bus.write_strb);
            end
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (bus.write_addr == f_period_addr(ch)) begin
                    r_period_stg[ch] <= f_merge(r_period_stg[ch], bus.write_data, bus.write_strb);
                end
                if (bus.write_addr == f_duty_addr(ch)) begin
                    r_duty_stg[ch] <= f_merge(r_duty_stg[ch], bus.write_data, bus.write_strb);
                end
            end
        end
    end

    // Enable bit and update request; a new request outranks a same-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_ctrl_lane0_wr) begin
                r_enable <= bus.write_data[CTRL_ENABLE];
            end
            if (w_update_req) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Commit uses pre-edge staging, so a same-cycle staging write is not picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_act <= '0;
            r_period_act   <= '0;
            r_duty_act     <= '0;
        end else if (w_commit) begin
            r_prescale_act <= r_prescale_stg;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_period_act[ch] <= r_period_stg[ch];
                r_duty_act[ch]   <= (r_duty_stg[ch] > r_period_stg[ch]) ? r_period_stg[ch]
                                                                         : r_duty_stg[ch];
            end
        end
    end

    // Read mux over pre-edge state; STATUS and CTRL expose only their defined bits.
    always_comb begin
        w_rd_word = '0;
        if (bus.read_addr == ADDR_WIDTH'(ADDR_CTRL)) begin
            w_rd_word = REG_WIDTH'(r_enable);
        end else if (bus.read_addr == ADDR_WIDTH'(ADDR_STATUS)) begin
            w_rd_word = REG_WIDTH'(r_pending);
        end else if (bus.read_addr == ADDR_WIDTH'(ADDR_PRESCALE)) begin
            w_rd_word = r_prescale_stg;
        end
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (bus.read_addr == f_period_addr(ch)) begin
                w_rd_word = r_period_stg[ch];
            end
            if (bus.read_addr == f_duty_addr(ch)) begin
                w_rd_word = r_duty_stg[ch];
            end
        end
    end

    // Bus responses: one-cycle read latency and single-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_read_err   <= 1'b0;
            r_write_err  <= 1'b0;
        end else begin
            r_read_valid <= bus.read_en;
            r_read_err   <= bus.read_en && !w_rd_in_range;
            r_read_data  <= (bus.read_en && w_rd_in_range) ? w_rd_word : '0;
            r_write_err  <= bus.write_en && !w_wr_in_range;
        end
    end

    assign bus.read_data    = r_read_data;
    assign bus.read_valid   = r_read_valid;
    assign bus.read_err     = r_read_err;
    assign bus.write_err    = r_write_err;
    assign o_enable         = r_enable;
    assign o_update_pending = r_pending;
    assign o_prescale       = r_prescale_act;
    assign o_period         = r_period_act;
    assign o_duty           = r_duty_act;
endmodule

// File: tb/tb_pwm_shadow_regs.sv
// Bench for pwm_shadow_regs: directed scenarios against fixed values plus a randomized run
// checked every cycle against an address-indexed behavioural model.
module tb_pwm_shadow_regs;
    localparam int unsigned RW    = 16;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 3 + 2 * NCH;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    period_end;
    logic                    enable;
    logic                    pending;
    logic [RW-1:0]           prescale;
    logic [NCH-1:0][RW-1:0]  period;
    logic [NCH-1:0][RW-1:0]  duty;

    pwm_shadow_regs_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    pwm_shadow_regs #(.REG_WIDTH(RW), .NUM_CHANNELS(NCH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .i_period_end     (period_end),
        .o_enable         (enable),
        .o_update_pending (pending),
        .o_prescale       (prescale),
        .o_period         (period),
        .o_duty           (duty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: staging indexed by register address, active as plain arrays.
    logic [RW-1:0] m_reg  [DEPTH];
    logic [RW-1:0] m_per  [NCH];
    logic [RW-1:0] m_duty [NCH];
    logic [RW-1:0] m_pre, m_rdata;
    logic          m_en, m_pend, m_rvalid, m_rerr, m_werr;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_reg[i] = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            m_per[i]  = '0;
            m_duty[i] = '0;
        end
        m_pre = '0; m_rdata = '0;
        m_en = 1'b0; m_pend = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0; m_werr = 1'b0;
    endtask

    function automatic logic [RW-1:0] model_read(input int unsigned a);
        if (a == 0) return RW'(m_en);
        if (a == 1) return RW'(m_pend);
        return m_reg[a];
    endfunction

    // Advance one clock: update the model from the inputs seen at this edge, sample at +1.
    task automatic step();
        int unsigned ra, wa;
        bit commit, set_upd;
        ra = 32'(bus.read_addr);
        wa = 32'(bus.write_addr);
        m_rvalid = bus.read_en;
        m_rerr   = bus.read_en && (ra >= DEPTH);
        m_rdata  = (bus.read_en && ra < DEPTH) ? model_read(ra) : '0;
        m_werr   = bus.write_en && (wa >= DEPTH);
        commit   = !m_en || (period_end && m_pend);
        if (commit) begin
            m_pre = m_reg[2];
            for (int i = 0; i < int'(NCH); i++) begin
                m_per[i]  = m_reg[3 + 2*i];
                m_duty[i] = (m_reg[4 + 2*i] > m_reg[3 + 2*i]) ? m_reg[3 + 2*i] : m_reg[4 + 2*i];
            end
        end
        set_upd = bus.write_en && (wa == 0) && bus.write_strb[0] && bus.write_data[1];
        if (set_upd) m_pend = 1'b1;
        else if (commit) m_pend = 1'b0;
        if (bus.write_en && wa < DEPTH) begin
            if (wa == 0) begin
                if (bus.write_strb[0]) m_en = bus.write_data[0];
            end else if (wa >= 2) begin
                for (int b = 0; b < int'(RW/8); b++)
                    if (bus.write_strb[b]) m_reg[wa][8*b +: 8] = bus.write_data[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_en = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.write_strb = '0;
        bus.read_en = 1'b0; bus.read_addr = '0; period_end = 1'b0;
    endtask

    task automatic do_write(input int unsigned a, input logic [RW-1:0] d, input logic [1:0] s);
        bus.write_en = 1'b1; bus.write_addr = AW'(a); bus.write_data = d; bus.write_strb = s;
        step();
        bus.write_en = 1'b0;
    endtask

    task automatic do_read(input int unsigned a, output logic [RW-1:0] d,
                           output logic v, output logic e);
        bus.read_en = 1'b1; bus.read_addr = AW'(a);
        step();
        d = bus.read_data; v = bus.read_valid; e = bus.read_err;
        bus.read_en = 1'b0;
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [RW-1:0] d;
        logic v, e;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({enable, pending, bus.read_valid, bus.read_err, bus.write_err} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000",
                     {enable, pending, bus.read_valid, bus.read_err, bus.write_err}); else n_pass++;
        n_total++; if ({prescale, period, duty, bus.read_data} !== '0)
            $display("FAIL reset_regs got nonzero active/read_data exp=0"); else n_pass++;
        rst_n = 1'b1;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            do_read(a, d, v, e);
            n_total++; if (d !== '0 || v !== 1'b1 || e !== 1'b0)
                $display("FAIL reset_read a=%0d got d=%h v=%b e=%b exp d=0 v=1 e=0", a, d, v, e);
            else n_pass++;
        end
        step();
        n_total++; if (bus.read_valid !== 1'b0 || bus.read_data !== '0)
            $display("FAIL idle_read got v=%b d=%h exp v=0 d=0", bus.read_valid, bus.read_data);
        else n_pass++;
    endtask

    task automatic test_transparent();
        do_write(3, 16'd100, 2'b11);
        n_total++; if (period[0] !== 16'd0)
            $display("FAIL transp_early got=%0d exp=0", period[0]); else n_pass++;
        do_write(4, 16'd40, 2'b11);
        n_total++; if (period[0] !== 16'd100 || duty[0] !== 16'd0)
            $display("FAIL transp_p0 got p=%0d d=%0d exp p=100 d=0", period[0], duty[0]);
        else n_pass++;
        step();
        n_total++; if (duty[0] !== 16'd40)
            $display("FAIL transp_d0 got=%0d exp=40", duty[0]); else n_pass++;
    endtask

    task automatic test_double_buffer();
        do_write(0, 16'h0001, 2'b01);
        n_total++; if (enable !== 1'b1) $display("FAIL enable_set got=%b exp=1", enable);
        else n_pass++;
        do_write(4, 16'd70, 2'b11);
        pulse_pe();
        n_total++; if (duty[0] !== 16'd40 || pending !== 1'b0)
            $display("FAIL no_update got d=%0d p=%b exp d=40 p=0", duty[0], pending); else n_pass++;
        do_write(0, 16'h0003, 2'b01);
        n_total++; if (pending !== 1'b1) $display("FAIL pending_set got=%b exp=1", pending);
        else n_pass++;
        n_total++; if (duty[0] !== 16'd40) $display("FAIL pre_commit got=%0d exp=40", duty[0]);
        else n_pass++;
        pulse_pe();
        n_total++; if (duty[0] !== 16'd70 || pending !== 1'b0)
            $display("FAIL commit got d=%0d p=%b exp d=70 p=0", duty[0], pending); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [RW-1:0] d;
        logic v, e;
        do_write(5, 16'd50, 2'b11);
        do_write(6, 16'd80, 2'b11);
        do_write(0, 16'h0003, 2'b01);
        n_total++; if (duty[1] !== 16'd0) $display("FAIL clamp_hold got=%0d exp=0", duty[1]);
        else n_pass++;
        pulse_pe();
        n_total++; if (period[1] !== 16'd50 || duty[1] !== 16'd50)
            $display("FAIL clamp got p=%0d d=%0d exp p=50 d=50", period[1], duty[1]); else n_pass++;
        do_read(6, d, v, e);
        n_total++; if (d !== 16'd80 || v !== 1'b1)
            $display("FAIL clamp_stg got=%0d v=%b exp=80 v=1", d, v); else n_pass++;
    endtask

    task automatic test_errors();
        logic [RW-1:0] d;
        logic v, e;
        do_write(DEPTH, 16'hFFFF, 2'b11);
        n_total++; if (bus.write_err !== 1'b1) $display("FAIL werr got=%b exp=1", bus.write_err);
        else n_pass++;
        step();
        n_total++; if (bus.write_err !== 1'b0 || enable !== 1'b1 || duty[1] !== 16'd50)
            $display("FAIL werr_pulse got we=%b en=%b d1=%0d exp 0 1 50",
                     bus.write_err, enable, duty[1]); else n_pass++;
        do_read(DEPTH, d, v, e);
        n_total++; if (d !== '0 || v !== 1'b1 || e !== 1'b1)
            $display("FAIL rerr got d=%h v=%b e=%b exp d=0 v=1 e=1", d, v, e); else n_pass++;
        do_read(15, d, v, e);
        n_total++; if (d !== '0 || e !== 1'b1)
            $display("FAIL rerr15 got d=%h e=%b exp d=0 e=1", d, e); else n_pass++;
        do_write(2, 16'h1234, 2'b11);
        do_write(2, 16'hABCD, 2'b01);
        do_read(2, d, v, e);
        n_total++; if (d !== 16'h12CD) $display("FAIL strb got=%h exp=12cd", d); else n_pass++;
        bus.write_en = 1'b1; bus.write_addr = AW'(2); bus.write_data = 16'h5555;
        bus.write_strb = 2'b11; bus.read_en = 1'b1; bus.read_addr = AW'(2);
        step();
        idle_inputs();
        n_total++; if (bus.read_data !== 16'h12CD)
            $display("FAIL rw_same got=%h exp=12cd", bus.read_data); else n_pass++;
        do_write(1, 16'hFFFF, 2'b11);
        n_total++; if (bus.write_err !== 1'b0 || pending !== 1'b0)
            $display("FAIL status_wr got we=%b p=%b exp 0 0", bus.write_err, pending); else n_pass++;
        do_read(2, d, v, e);
        n_total++; if (d !== 16'h5555) $display("FAIL rw_new got=%h exp=5555", d); else n_pass++;
    endtask

    task automatic test_set_wins();
        do_write(0, 16'h0003, 2'b01);
        bus.write_en = 1'b1; bus.write_addr = AW'(0); bus.write_data = 16'h0003;
        bus.write_strb = 2'b01; period_end = 1'b1;
        step();
        idle_inputs();
        n_total++; if (prescale !== 16'h5555 || pending !== 1'b1)
            $display("FAIL set_wins got pre=%h p=%b exp pre=5555 p=1", prescale, pending);
        else n_pass++;
        pulse_pe();
        n_total++; if (pending !== 1'b0) $display("FAIL set_wins_clr got=%b exp=0", pending);
        else n_pass++;
    endtask

    task automatic test_random();
        int unsigned wa;
        for (int cyc = 0; cyc < 600; cyc++) begin
            wa = ($urandom % 3 == 0) ? 0 : $urandom_range(0, 15);
            bus.write_en   = ($urandom % 3 != 0);
            bus.write_addr = AW'(wa);
            bus.write_data = RW'($urandom);
            if (wa == 0) bus.write_data[0] = ($urandom % 4 != 0);
            bus.write_strb = 2'($urandom);
            bus.read_en    = ($urandom % 2 == 0);
            bus.read_addr  = AW'($urandom_range(0, 15));
            period_end     = ($urandom % 4 == 0);
            step();
            n_total++; if (bus.read_valid !== m_rvalid || bus.read_err !== m_rerr ||
                           bus.read_data !== m_rdata)
                $display("FAIL rand_read cyc=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h", cyc,
                         bus.read_valid, bus.read_err, bus.read_data, m_rvalid, m_rerr, m_rdata);
            else n_pass++;
            n_total++; if (bus.write_err !== m_werr || enable !== m_en || pending !== m_pend)
                $display("FAIL rand_ctrl cyc=%0d got we=%b en=%b p=%b exp we=%b en=%b p=%b", cyc,
                         bus.write_err, enable, pending, m_werr, m_en, m_pend);
            else n_pass++;
            n_total++; if (prescale !== m_pre)
                $display("FAIL rand_pre cyc=%0d got=%h exp=%h", cyc, prescale, m_pre);
            else n_pass++;
            for (int i = 0; i < int'(NCH); i++) begin
                n_total++; if (period[i] !== m_per[i] || duty[i] !== m_duty[i])
                    $display("FAIL rand_ch%0d cyc=%0d got p=%h d=%h exp p=%h d=%h", i, cyc,
                             period[i], duty[i], m_per[i], m_duty[i]);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_pending();
        do_write(0, 16'h0000, 2'b01);
        do_write(2, 16'hBEEF, 2'b11);
        do_write(3, 16'h0123, 2'b11);
        step();
        n_total++; if (prescale !== 16'hBEEF || period[0] !== 16'h0123)
            $display("FAIL mid_setup got pre=%h p0=%h exp beef 0123", prescale, period[0]);
        else n_pass++;
        do_write(0, 16'h0003, 2'b01);
        n_total++; if (pending !== 1'b1 || enable !== 1'b1)
            $display("FAIL mid_pend got p=%b en=%b exp 1 1", pending, enable); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_total++; if ({enable, pending, bus.read_valid, bus.read_err, bus.write_err} !== 5'b0 ||
                       {prescale, period, duty, bus.read_data} !== '0)
            $display("FAIL mid_reset got en=%b p=%b pre=%h p0=%h exp all 0",
                     enable, pending, prescale, period[0]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_pe();
        n_total++; if (pending !== 1'b0 || prescale !== '0)
            $display("FAIL mid_discard got p=%b pre=%h exp p=0 pre=0", pending, prescale);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_transparent();
        test_double_buffer();
        test_clamp();
        test_errors();
        test_set_wins();
        test_random();
        test_reset_mid_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
